// File: rtl/teeod_ipc_axil_frontend.sv
// AXI4-Lite slave -> single-beat register request bridge; write strobe 1 cycle after AW+W, BVALID 1 later, read strobe 1 cycle after AR.
// Back-pressure: one write and one read outstanding; AW/W/AR stall until the matching B/R handshake completes.
module teeod_ipc_axil_frontend #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              reg_wr_en,
    output logic [C_S_AXI_ADDR_WIDTH-3:0]     reg_wr_idx,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg_wr_data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   reg_wr_strb,
    output logic                              reg_rd_en,
    output logic [C_S_AXI_ADDR_WIDTH-3:0]     reg_rd_idx,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     reg_rd_data,
    input  logic                              reg_rd_valid
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} rd_state_t;

    wr_state_t        wr_state_q, wr_state_d;
    rd_state_t        rd_state_q, rd_state_d;
    logic             ready_en_q;
    logic             aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d, ar_idx_q, ar_idx_d;
    logic [DW-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;
    logic [SW-1:0]    wstrb_q, wstrb_d;
    logic [1:0]       bresp_q, bresp_d, rresp_q, rresp_d;
    logic             last_grant_q, last_grant_d;
    logic             aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic             wr_ok, rd_ok, wr_rdy, rd_rdy, grant_wr, grant_rd;
    logic             unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // ready_en_q keeps the READY outputs low for the whole reset period.
    assign S_AXI_AWREADY = ready_en_q & ~aw_full_q;
    assign S_AXI_WREADY  = ready_en_q & ~w_full_q;
    assign S_AXI_ARREADY = ready_en_q & (rd_state_q == R_IDLE);
    assign S_AXI_BVALID  = (wr_state_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = (rd_state_q == R_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
    assign b_hs  = S_AXI_BVALID & S_AXI_BREADY;
    assign r_hs  = S_AXI_RVALID & S_AXI_RREADY;

    assign wr_ok  = 32'(aw_idx_q) < 32'(NUM_REGS);
    assign rd_ok  = 32'(ar_idx_q) < 32'(NUM_REGS);
    assign wr_rdy = (wr_state_q == W_ISSUE);
    assign rd_rdy = (rd_state_q == R_REQ);

    // last_grant_q only moves on contention, so back-to-back collisions alternate.
    assign grant_wr     = wr_rdy & (~rd_rdy | ~last_grant_q);
    assign grant_rd     = rd_rdy & (~wr_rdy | last_grant_q);
    assign last_grant_d = (wr_rdy & rd_rdy) ? grant_wr : last_grant_q;

    assign reg_wr_en   = grant_wr & wr_ok;
    assign reg_wr_idx  = aw_idx_q;
    assign reg_wr_data = wdata_q;
    assign reg_wr_strb = wstrb_q;
    assign reg_rd_en   = grant_rd & rd_ok;
    assign reg_rd_idx  = ar_idx_q;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_full_d  = aw_full_q | aw_hs;
        w_full_d   = w_full_q | w_hs;
        aw_idx_d   = aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
        wdata_d    = w_hs ? S_AXI_WDATA : wdata_q;
        wstrb_d    = w_hs ? S_AXI_WSTRB : wstrb_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE:  if (aw_full_d && w_full_d) wr_state_d = W_ISSUE;
            W_ISSUE: if (grant_wr) begin
                wr_state_d = W_RESP;
                bresp_d    = wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
            W_RESP:  if (b_hs) begin
                wr_state_d = W_IDLE;
                aw_full_d  = 1'b0;
                w_full_d   = 1'b0;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        ar_idx_d   = ar_idx_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: if (ar_hs) begin
                ar_idx_d   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
                rd_state_d = R_REQ;
            end
            R_REQ: if (grant_rd) begin
                if (rd_ok) begin
                    rd_state_d = R_WAIT;
                end else begin
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                    rd_state_d = R_RESP;
                end
            end
            R_WAIT: if (reg_rd_valid) begin
                rdata_d    = reg_rd_data;
                rresp_d    = RESP_OKAY;
                rd_state_d = R_RESP;
            end
            R_RESP: if (r_hs) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state_q   <= W_IDLE;
            rd_state_q   <= R_IDLE;
            ready_en_q   <= 1'b0;
            aw_full_q    <= 1'b0;
            w_full_q     <= 1'b0;
            aw_idx_q     <= '0;
            ar_idx_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            bresp_q      <= RESP_OKAY;
            rresp_q      <= RESP_OKAY;
            last_grant_q <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            rd_state_q   <= rd_state_d;
            ready_en_q   <= 1'b1;
            aw_full_q    <= aw_full_d;
            w_full_q     <= w_full_d;
            aw_idx_q     <= aw_idx_d;
            ar_idx_q     <= ar_idx_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdata_q      <= rdata_d;
            bresp_q      <= bresp_d;
            rresp_q      <= rresp_d;
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: tb/tb_teeod_ipc_axil_frontend.sv
// Directed bench for teeod_ipc_axil_frontend with a small register-file model behind it.
module tb_teeod_ipc_axil_frontend;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  S_AXI_AWADDR, S_AXI_ARADDR;
    logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic        reg_wr_en, reg_rd_en, reg_rd_valid;
    logic [2:0]  reg_wr_idx, reg_rd_idx;
    logic [31:0] reg_wr_data, reg_rd_data;
    logic [3:0]  reg_wr_strb;

    int n_tests = 0;
    int n_fail  = 0;

    // Register model: returns data rd_lat cycles after reg_rd_en.
    logic [31:0] model [8];
    logic [31:0] rd_dat = '0;
    int          rd_cnt_dn = 0;
    int          rd_lat = 3;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic        overlap = 1'b0;
    logic [31:0] tmp;

    always #5 clk = ~clk;

    teeod_ipc_axil_frontend #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .NUM_REGS(4)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data),
        .reg_wr_strb(reg_wr_strb), .reg_rd_en(reg_rd_en), .reg_rd_idx(reg_rd_idx),
        .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid)
    );

    assign reg_rd_valid = (rd_cnt_dn == 1);
    assign reg_rd_data  = rd_dat;

    always @(posedge clk) begin
        if (reg_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            tmp = model[reg_wr_idx];
            for (int b = 0; b < 4; b++)
                if (reg_wr_strb[b]) tmp[8*b +: 8] = reg_wr_data[8*b +: 8];
            model[reg_wr_idx] = tmp;
        end
        if (reg_rd_en) begin
            rd_cnt    <= rd_cnt + 1;
            rd_dat    <= model[reg_rd_idx];
            rd_cnt_dn <= rd_lat;
        end else if (rd_cnt_dn != 0) begin
            rd_cnt_dn <= rd_cnt_dn - 1;
        end
        if (reg_wr_en && reg_rd_en) overlap <= 1'b1;
    end

    wire [20:0] ctl_vec = {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_BRESP,
                           S_AXI_RVALID, S_AXI_RRESP, reg_wr_en, reg_rd_en, reg_wr_idx,
                           reg_rd_idx, reg_wr_strb};
    wire [63:0] dat_vec = {S_AXI_RDATA, reg_wr_data};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input logic exp_en, input logic [1:0] exp_resp);
        int n;
        S_AXI_AWADDR = addr;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        if (w_lead > 0) begin
            S_AXI_WVALID = 1'b1;
            n = 0;
            while (!S_AXI_WREADY && n < 20) begin tick(); n++; end
            chk("wr_wready", S_AXI_WREADY, 1);
            tick();
            S_AXI_WVALID = 1'b0;
            repeat (w_lead - 1) tick();
            S_AXI_AWVALID = 1'b1;
            n = 0;
            while (!S_AXI_AWREADY && n < 20) begin tick(); n++; end
            chk("wr_awready", S_AXI_AWREADY, 1);
            tick();
            S_AXI_AWVALID = 1'b0;
        end else begin
            S_AXI_WVALID  = 1'b1;
            S_AXI_AWVALID = 1'b1;
            n = 0;
            while (!(S_AXI_WREADY && S_AXI_AWREADY) && n < 20) begin tick(); n++; end
            chk("wr_both_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
            tick();
            S_AXI_WVALID  = 1'b0;
            S_AXI_AWVALID = 1'b0;
        end
        chk("wr_en", reg_wr_en, exp_en);
        if (exp_en) begin
            chk("wr_idx", reg_wr_idx, addr[4:2]);
            chk("wr_data", reg_wr_data, data);
            chk("wr_strb", reg_wr_strb, strb);
        end
        chk("wr_bvalid_early", S_AXI_BVALID, 0);
        tick();
        chk("wr_bvalid", S_AXI_BVALID, 1);
        chk("wr_bresp", S_AXI_BRESP, exp_resp);
    endtask

    task automatic b_ack();
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        chk("b_ack_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b110);
    endtask

    task automatic r_ack();
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        chk("r_ack_ready", {S_AXI_ARREADY, S_AXI_RVALID}, 2'b10);
    endtask

    task automatic wait_rvalid();
        int n = 0;
        while (!S_AXI_RVALID && n < 30) begin tick(); n++; end
        chk("rvalid_wait", S_AXI_RVALID, 1);
    endtask

    task automatic do_read(input logic [4:0] addr, input logic exp_en,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin tick(); n++; end
        chk("rd_arready", S_AXI_ARREADY, 1);
        tick();
        S_AXI_ARVALID = 1'b0;
        chk("rd_en", reg_rd_en, exp_en);
        if (exp_en) begin
            chk("rd_idx", reg_rd_idx, addr[4:2]);
            n = 0;
            while (!reg_rd_valid && n < 20) begin tick(); n++; end
            chk("rd_lat", n, rd_lat);
        end
        chk("rd_rvalid_early", S_AXI_RVALID, 0);
        tick();
        chk("rd_rvalid", S_AXI_RVALID, 1);
        chk("rd_rdata", S_AXI_RDATA, exp_data);
        chk("rd_rresp", S_AXI_RRESP, exp_resp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, rc;
        rst = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = '0;

        tick();
        chk("reset_ctl", ctl_vec, 0);
        chk("reset_dat", dat_vec, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_reset_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        // W leads AW by 2 cycles
        for (int i = 0; i < 4; i++) begin
            do_write(5'(4 * i), 32'(i + 1), 4'hF, 2, 1'b1, 2'b00);
            b_ack();
        end
        rd_lat = 3;
        for (int i = 0; i < 4; i++) begin
            do_read(5'(4 * i), 1'b1, 32'(i + 1), 2'b00);
            r_ack();
        end

        // out-of-range decode
        wc = wr_cnt;
        do_write(5'h10, 32'hDEAD, 4'hF, 0, 1'b0, 2'b10);
        b_ack();
        chk("oor_no_wr", wr_cnt, wc);
        rc = rd_cnt;
        do_read(5'h1C, 1'b0, 32'h0, 2'b10);
        r_ack();
        chk("oor_no_rd", rd_cnt, rc);

        // unaligned address with zero strobe: pulse fires, register unchanged
        do_write(5'h07, 32'hFFFF_FFFF, 4'h0, 0, 1'b1, 2'b00);
        b_ack();
        do_read(5'h04, 1'b1, 32'h2, 2'b00);
        r_ack();

        // hold B and R for 10 cycles with new requests knocking
        do_write(5'h04, 32'h1234_5678, 4'hF, 1, 1'b1, 2'b00);
        do_read(5'h0C, 1'b1, 32'h4, 2'b00);
        wc = wr_cnt;
        rc = rd_cnt;
        S_AXI_AWADDR = 5'h08; S_AXI_ARADDR = 5'h08;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_RVALID, S_AXI_RRESP, S_AXI_AWREADY,
                         S_AXI_WREADY, S_AXI_ARREADY, S_AXI_RDATA},
                {1'b1, 2'b00, 1'b1, 2'b00, 3'b000, 32'h4});
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        chk("hold_no_strobe", {wr_cnt, rd_cnt}, {wc, rc});
        b_ack();
        r_ack();

        // collision after reset: write wins, then read sees new value
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        S_AXI_AWADDR = 5'h08; S_AXI_WDATA = 32'hA5A5_A5A5; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 5'h08;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        chk("col1_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        chk("col1_first", {reg_wr_en, reg_rd_en, reg_wr_idx, reg_wr_data}, {2'b10, 3'd2, 32'hA5A5_A5A5});
        tick();
        chk("col1_second", {reg_wr_en, reg_rd_en, reg_rd_idx, S_AXI_BVALID}, {2'b01, 3'd2, 1'b1});
        wait_rvalid();
        chk("col1_rdata", {S_AXI_RDATA, S_AXI_RRESP}, {32'hA5A5_A5A5, 2'b00});
        b_ack();
        r_ack();

        // repeated collision: read wins and returns the old value
        S_AXI_WDATA = 32'h5A5A_5A5A;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        chk("col2_first", {reg_wr_en, reg_rd_en}, 2'b01);
        tick();
        chk("col2_second", {reg_wr_en, reg_rd_en, reg_wr_data}, {2'b10, 32'h5A5A_5A5A});
        wait_rvalid();
        chk("col2_rdata", S_AXI_RDATA, 32'hA5A5_A5A5);
        tick();
        chk("col2_bvalid", S_AXI_BVALID, 1);
        b_ack();
        r_ack();
        do_read(5'h08, 1'b1, 32'h5A5A_5A5A, 2'b00);
        r_ack();

        // reset with read in R_WAIT and BVALID pending
        do_write(5'h00, 32'h77, 4'hF, 0, 1'b1, 2'b00);
        rd_lat = 6;
        S_AXI_ARADDR  = 5'h04;
        S_AXI_ARVALID = 1'b1;
        chk("rst_arready", S_AXI_ARREADY, 1);
        tick();
        S_AXI_ARVALID = 1'b0;
        chk("rst_rd_en", reg_rd_en, 1);
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_ctl", ctl_vec, 0);
        chk("midrst_dat", dat_vec, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_release", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID},
            5'b11100);
        do_write(5'h0C, 32'h99, 4'hF, 0, 1'b1, 2'b00);
        b_ack();
        tick();
        tick();
        chk("stale_ignored", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b01);
        rd_lat = 1;
        do_read(5'h0C, 1'b1, 32'h99, 2'b00);
        r_ack();

        chk("no_wr_rd_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
